// File: rtl/csi_pkg.sv
// Shared types and constants for the CSI extractor front end.
// Sample field positions, detector FSM encoding and a constant-width helper.
package csi_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      LOCKED = 2'd2
   } spd_state_t;

   localparam int I_MSB = 31;
   localparam int I_LSB = 16;
   localparam int Q_MSB = 15;
   localparam int Q_LSB = 0;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Enabled shift register with async active-low clear; dout_o is the entry
// pushed DEPTH enables ago (zero until the line has been filled).
module sample_delay_line #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             en_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      end else if (en_i) begin
         mem_q[0] <= din_i;
         for (int k = 1; k < DEPTH; k++) mem_q[k] <= mem_q[k-1];
      end
   end

   assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/short_preamble_detector.sv
// Legacy STF detector: lag-LAG autocorrelation over a WIN_LEN window compared
// against windowed power, confirmed by a plateau of qualifying metric strobes.
//
//   state  | meaning
//   IDLE   | trigger low, plateau counter held at zero
//   SEARCH | trigger high, counting consecutive qualifying metric strobes
//   LOCKED | STF confirmed, locked_out high until trigger_in falls
module short_preamble_detector
   import csi_pkg::*;
#(
   parameter int LAG       = 16,
   parameter int WIN_LEN   = 48,
   parameter int ACC_W     = 40,
   parameter int RATIO_NUM = 3
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [31:0]      signal_data_in,
   input  logic             signal_valid_in,
   input  logic             trigger_in,
   input  logic [15:0]      min_plateau_in,
   output logic [ACC_W-1:0] metric_mag_out,
   output logic [ACC_W-1:0] metric_pow_out,
   output logic             metric_valid_out,
   output logic             detected_out,
   output logic             locked_out
);

   localparam int FILL_N = LAG + WIN_LEN;
   localparam int FILL_W = clog2(FILL_N + 1);
   localparam int CMP_W  = ACC_W + 3;

   function automatic logic [ACC_W-1:0] sext33(input logic [32:0] v);
      return {{(ACC_W-33){v[32]}}, v};
   endfunction

   function automatic logic [ACC_W-1:0] zext33(input logic [32:0] v);
      return {{(ACC_W-33){1'b0}}, v};
   endfunction

   function automatic logic [ACC_W-1:0] abs_acc(input logic [ACC_W-1:0] v);
      return v[ACC_W-1] ? (ACC_W'(0) - v) : v;
   endfunction

   // ---------------- stage 1: lag product and instantaneous power
   logic [31:0]        lag_data;
   logic signed [32:0] s_i, s_q, d_i, d_q;
   logic signed [32:0] prod_re_d, prod_im_d, pwr_d;
   logic [32:0]        prod_re_q, prod_im_q, pwr_q;
   logic               v1_q;

   sample_delay_line #(.WIDTH(32), .DEPTH(LAG)) u_lag_line (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .en_i   (signal_valid_in),
      .din_i  (signal_data_in),
      .dout_o (lag_data)
   );

   // 33-bit operands keep every product and sum exact (max magnitude 2^31)
   assign s_i = {{17{signal_data_in[I_MSB]}}, signal_data_in[I_MSB:I_LSB]};
   assign s_q = {{17{signal_data_in[Q_MSB]}}, signal_data_in[Q_MSB:Q_LSB]};
   assign d_i = {{17{lag_data[I_MSB]}}, lag_data[I_MSB:I_LSB]};
   assign d_q = {{17{lag_data[Q_MSB]}}, lag_data[Q_MSB:Q_LSB]};

   assign prod_re_d = s_i * d_i + s_q * d_q;
   assign prod_im_d = s_q * d_i - s_i * d_q;
   assign pwr_d     = s_i * s_i + s_q * s_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         prod_re_q <= '0;
         prod_im_q <= '0;
         pwr_q     <= '0;
         v1_q      <= 1'b0;
      end else begin
         v1_q <= signal_valid_in;
         if (signal_valid_in) begin
            prod_re_q <= prod_re_d;
            prod_im_q <= prod_im_d;
            pwr_q     <= pwr_d;
         end
      end
   end

   // ---------------- stage 2: moving sums over WIN_LEN stage-1 outputs
   logic [65:0]       prod_old;
   logic [32:0]       pwr_old;
   logic [ACC_W-1:0]  corr_re_q, corr_im_q, pow_q;
   logic              v2_q;

   sample_delay_line #(.WIDTH(66), .DEPTH(WIN_LEN)) u_prod_line (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .en_i   (v1_q),
      .din_i  ({prod_re_q, prod_im_q}),
      .dout_o (prod_old)
   );

   sample_delay_line #(.WIDTH(33), .DEPTH(WIN_LEN)) u_pwr_line (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .en_i   (v1_q),
      .din_i  (pwr_q),
      .dout_o (pwr_old)
   );

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         corr_re_q <= '0;
         corr_im_q <= '0;
         pow_q     <= '0;
         v2_q      <= 1'b0;
      end else begin
         v2_q <= v1_q;
         if (v1_q) begin
            corr_re_q <= corr_re_q + sext33(prod_re_q) - sext33(prod_old[65:33]);
            corr_im_q <= corr_im_q + sext33(prod_im_q) - sext33(prod_old[32:0]);
            pow_q     <= pow_q + zext33(pwr_q) - zext33(pwr_old);
         end
      end
   end

   // ---------------- stage 3: magnitude approximation and fill tracking
   logic [ACC_W-1:0]  abs_re, abs_im, mag_d;
   logic [FILL_W-1:0] fill_cnt_q;
   logic              fill_done_q;

   assign abs_re = abs_acc(corr_re_q);
   assign abs_im = abs_acc(corr_im_q);
   assign mag_d  = (abs_re > abs_im) ? abs_re + (abs_im >> 2) : abs_im + (abs_re >> 2);

   // fill_done travels with the metric it describes, so gaps cannot skew it
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         metric_mag_out   <= '0;
         metric_pow_out   <= '0;
         metric_valid_out <= 1'b0;
         fill_cnt_q       <= '0;
         fill_done_q      <= 1'b0;
      end else begin
         metric_valid_out <= v2_q;
         if (v2_q) begin
            metric_mag_out <= mag_d;
            metric_pow_out <= pow_q;
            if (fill_cnt_q != FILL_W'(FILL_N)) fill_cnt_q <= fill_cnt_q + FILL_W'(1);
            fill_done_q <= fill_done_q | (fill_cnt_q == FILL_W'(FILL_N - 1));
         end
      end
   end

   // ---------------- plateau FSM
   logic [CMP_W-1:0] cmp_lhs, cmp_rhs;
   logic             qualify;
   logic [15:0]      plateau_q, plateau_inc, min_eff;
   spd_state_t       state_q;

   assign cmp_lhs     = {3'b000, metric_mag_out} << 2;
   assign cmp_rhs     = CMP_W'(RATIO_NUM) * {3'b000, metric_pow_out};
   assign qualify     = fill_done_q && (cmp_lhs > cmp_rhs) && (metric_pow_out != '0);
   assign plateau_inc = (plateau_q == 16'hFFFF) ? plateau_q : plateau_q + 16'd1;
   assign min_eff     = (min_plateau_in == 16'd0) ? 16'd1 : min_plateau_in;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q      <= IDLE;
         plateau_q    <= '0;
         detected_out <= 1'b0;
         locked_out   <= 1'b0;
      end else begin
         detected_out <= 1'b0;
         unique case (state_q)
            IDLE: begin
               plateau_q <= '0;
               if (trigger_in) state_q <= SEARCH;
            end
            SEARCH: begin
               if (!trigger_in) begin
                  state_q   <= IDLE;
                  plateau_q <= '0;
               end else if (metric_valid_out) begin
                  if (qualify) begin
                     plateau_q <= plateau_inc;
                     if (plateau_inc == min_eff) begin
                        detected_out <= 1'b1;
                        locked_out   <= 1'b1;
                        state_q      <= LOCKED;
                     end
                  end else begin
                     plateau_q <= '0;
                  end
               end
            end
            LOCKED: begin
               if (!trigger_in) begin
                  state_q    <= IDLE;
                  locked_out <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_short_preamble_detector.sv
// Directed bench for short_preamble_detector: every metric strobe is compared
// against a direct windowed-sum model of the sample history since reset.
module tb_short_preamble_detector;

   localparam int ACC_W = 40;

   logic             clk_in = 1'b0;
   logic             rst_in = 1'b0;
   logic [31:0]      signal_data_in = '0;
   logic             signal_valid_in = 1'b0;
   logic             trigger_in = 1'b0;
   logic [15:0]      min_plateau_in = 16'd20;
   logic [ACC_W-1:0] metric_mag_out, metric_pow_out;
   logic             metric_valid_out, detected_out, locked_out;

   int     hist_i [4096];
   int     hist_q [4096];
   int     n_sent, n_strobe, det_cnt, det_strobe;
   int     n_checks, n_fail;
   int     det0, base;
   longint per_pow, em, ep;

   short_preamble_detector dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .signal_data_in   (signal_data_in),
      .signal_valid_in  (signal_valid_in),
      .trigger_in       (trigger_in),
      .min_plateau_in   (min_plateau_in),
      .metric_mag_out   (metric_mag_out),
      .metric_pow_out   (metric_pow_out),
      .metric_valid_out (metric_valid_out),
      .detected_out     (detected_out),
      .locked_out       (locked_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int stf_i(input int k);
      return ((k * 5) % 7 - 3) * 2000;
   endfunction

   function automatic int stf_q(input int k);
      return ((k * 3) % 5 - 2) * 4000;
   endfunction

   // direct (non-recursive) window sums for the k-th sample since reset
   function automatic void exp_metric(input int k, output longint mag, output longint pow);
      longint re = 0, im = 0, ar, ai;
      pow = 0;
      for (int m = k - 47; m <= k; m++) begin
         if (m >= 0) begin
            pow += longint'(hist_i[m]) * hist_i[m] + longint'(hist_q[m]) * hist_q[m];
            if (m >= 16) begin
               re += longint'(hist_i[m]) * hist_i[m-16] + longint'(hist_q[m]) * hist_q[m-16];
               im += longint'(hist_q[m]) * hist_i[m-16] - longint'(hist_i[m]) * hist_q[m-16];
            end
         end
      end
      ar  = (re < 0) ? -re : re;
      ai  = (im < 0) ? -im : im;
      mag = (ar > ai) ? ar + (ai >>> 2) : ai + (ar >>> 2);
   endfunction

   always @(negedge clk_in) begin
      if (!rst_in) begin
         n_strobe = 0;
      end else begin
         if (detected_out) begin
            det_cnt++;
            det_strobe = n_strobe;
         end
         if (metric_valid_out) begin
            exp_metric(n_strobe, em, ep);
            chk("metric_mag", longint'(metric_mag_out), em);
            chk("metric_pow", longint'(metric_pow_out), ep);
            n_strobe++;
         end
      end
   end

   task automatic send(input int i, input int q);
      @(negedge clk_in);
      signal_data_in  = {16'(i), 16'(q)};
      signal_valid_in = 1'b1;
      hist_i[n_sent]  = i;
      hist_q[n_sent]  = q;
      n_sent++;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_in);
         signal_valid_in = 1'b0;
      end
   endtask

   task automatic send_stf(input int n, input bit gaps);
      for (int j = 0; j < n; j++) begin
         if (gaps) while ($urandom_range(1) == 1) idle(1);
         send(stf_i(n_sent % 16), stf_q(n_sent % 16));
      end
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      rst_in = 1'b0;
      signal_valid_in = 1'b0;
      idle(2);
      n_sent = 0;
      @(negedge clk_in);
      rst_in = 1'b1;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_mag"},    longint'(metric_mag_out), 0);
      chk({tag, "_pow"},    longint'(metric_pow_out), 0);
      chk({tag, "_mvalid"}, longint'(metric_valid_out), 0);
      chk({tag, "_det"},    longint'(detected_out), 0);
      chk({tag, "_locked"}, longint'(locked_out), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      per_pow = 0;
      for (int k = 0; k < 16; k++)
         per_pow += longint'(stf_i(k)) * stf_i(k) + longint'(stf_q(k)) * stf_q(k);

      #12;
      chk_outputs_zero("reset");
      @(negedge clk_in);
      rst_in     = 1'b1;
      trigger_in = 1'b1;

      // fill: 63 STF samples may not detect
      det0 = det_cnt;
      send_stf(63, 0);
      idle(4);
      chk("fill_no_det", det_cnt - det0, 0);
      chk("fill_strobes", n_strobe, 63);

      // 64th sample: metric strobe exactly three cycles after acceptance
      send(stf_i(n_sent % 16), stf_q(n_sent % 16));
      idle(2);
      chk("latency_early", longint'(metric_valid_out), 0);
      idle(1);
      chk("latency_3", longint'(metric_valid_out), 1);

      // ideal STF to 200 samples
      send_stf(136, 0);
      idle(4);
      chk("stf_det_count", det_cnt - det0, 1);
      chk("stf_det_strobe", det_strobe, 83);
      chk("stf_locked", longint'(locked_out), 1);
      chk("stf_pow_steady", longint'(metric_pow_out), 3 * per_pow);
      chk("stf_mag_steady", longint'(metric_mag_out), 3 * per_pow);

      // trigger drop while locked
      @(negedge clk_in);
      trigger_in = 1'b0;
      chk("locked_before_edge", longint'(locked_out), 1);
      @(posedge clk_in);
      #1;
      chk("locked_falls", longint'(locked_out), 0);

      // trigger drop in SEARCH after 10 qualifying strobes restarts the plateau
      @(negedge clk_in);
      trigger_in = 1'b1;
      idle(2);
      det0 = det_cnt;
      send_stf(10, 0);
      idle(4);
      trigger_in = 1'b0;
      idle(3);
      trigger_in = 1'b1;
      idle(2);
      chk("drop_no_det", det_cnt - det0, 0);
      base = n_strobe;
      send_stf(30, 0);
      idle(4);
      chk("redo_det_count", det_cnt - det0, 1);
      chk("redo_det_strobe", det_strobe - base, 20);
      chk("redo_locked", longint'(locked_out), 1);

      // asynchronous reset in the middle of a stream
      send_stf(5, 0);
      #2;
      rst_in = 1'b0;
      #1;
      chk_outputs_zero("midreset");
      idle(2);
      n_sent = 0;
      @(negedge clk_in);
      rst_in = 1'b1;

      // same STF with ~50% valid duty
      det0 = det_cnt;
      send_stf(200, 1);
      idle(4);
      chk("gap_det_count", det_cnt - det0, 1);
      chk("gap_det_strobe", det_strobe, 83);
      chk("gap_strobes", n_strobe, 200);

      // uniform noise never detects
      do_reset();
      det0 = det_cnt;
      for (int j = 0; j < 2000; j++)
         send(int'($urandom_range(16000)) - 8000, int'($urandom_range(16000)) - 8000);
      idle(4);
      chk("noise_no_det", det_cnt - det0, 0);

      // min_plateau_in = 0 behaves as 1: first qualifying strobe detects
      do_reset();
      min_plateau_in = 16'd0;
      det0 = det_cnt;
      send_stf(70, 0);
      idle(4);
      chk("min0_det_count", det_cnt - det0, 1);
      chk("min0_det_strobe", det_strobe, 64);

      // full-scale negative DC, trigger low: metrics still run, no overflow
      do_reset();
      min_plateau_in = 16'd20;
      trigger_in = 1'b0;
      det0 = det_cnt;
      for (int j = 0; j < 70; j++) send(-32768, -32768);
      idle(4);
      chk("dc_pow", longint'(metric_pow_out), 64'd103079215104);
      chk("dc_mag", longint'(metric_mag_out), 64'd103079215104);
      chk("dc_no_det", det_cnt - det0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
